// File: rtl/gpr_file_sb_pkg.sv
// Shared core types: default register-file geometry and register-index/word types.
package gpr_file_sb_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/gpr_file_sb_bits.sv
// Busy-bit scoreboard: one pending-producer flag per register, issue (set) beats write-back (clear).
module gpr_sb_bits
    import gpr_file_sb_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREGS-1:0] set_vec,
    input  logic [NREGS-1:0] clr_vec,
    output logic [NREGS-1:0] busy
);

    // x0 is hard-wired idle regardless of what the callers present
    localparam logic [NREGS-1:0] X0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

    // Clear first, then set, so a same-cycle newer producer keeps the bit high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~clr_vec) | set_vec) & X0_MASK;
        end
    end

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-port general-purpose register file with write-back bypass and busy scoreboard.
module gpr_file_sb
    import gpr_file_sb_pkg::*;
#(
    parameter  int unsigned XLEN  = XLEN_DEF,
    parameter  int unsigned NREGS = NREGS_DEF,
    parameter  int unsigned NRD   = 2,
    parameter  int unsigned NWR   = 2,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NWR-1:0]       wb_wen,
    input  logic [NWR*AW-1:0]    wb_rd,
    input  logic [NWR*XLEN-1:0]  wb_data,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        dbg_addr,
    output logic [XLEN-1:0]      dbg_data
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_val [NREGS];
    logic [NREGS-1:0] iss_vec;
    logic [NREGS-1:0] busy;

    // Per-register write resolution; later (higher-index) ports override earlier ones
    always_comb begin
        wr_hit = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            wr_val[r] = '0;
        end
        for (int unsigned p = 0; p < NWR; p++) begin
            if (wb_wen[p] && (wb_rd[p*AW +: AW] != '0)) begin
                wr_hit[wb_rd[p*AW +: AW]] = 1'b1;
                wr_val[wb_rd[p*AW +: AW]] = wb_data[p*XLEN +: XLEN];
            end
        end
    end

    // One-hot issue claim; x0 never becomes busy
    always_comb begin
        iss_vec = '0;
        if (iss_valid && (iss_rd != '0)) begin
            iss_vec[iss_rd] = 1'b1;
        end
    end

    // Architectural storage; x0 is only ever written by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
        end
    end

    gpr_sb_bits #(
        .NREGS (NREGS)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_vec (iss_vec),
        .clr_vec (wr_hit),
        .busy    (busy)
    );

    // Read ports: bypass the winning same-cycle write, busy drops with it unless re-claimed
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned j = 0; j < NRD; j++) begin
            if (wr_hit[rd_addr[j*AW +: AW]]) begin
                rd_data[j*XLEN +: XLEN] = wr_val[rd_addr[j*AW +: AW]];
            end else begin
                rd_data[j*XLEN +: XLEN] = regs_q[rd_addr[j*AW +: AW]];
            end
            rd_busy[j] = busy[rd_addr[j*AW +: AW]]
                       & ~(wr_hit[rd_addr[j*AW +: AW]] & ~iss_vec[rd_addr[j*AW +: AW]]);
        end
    end

    // Debug view of stored state only, no bypass
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: directed vector table, reset corner cases, random traffic vs. array model.
module tb_gpr_file_sb;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;
    localparam logic [63:0] V     = 64'h1234_5678_9ABC_DEF0;

    logic                clk;
    logic                rst;
    logic [NWR-1:0]      wb_wen;
    logic [NWR*AW-1:0]   wb_rd;
    logic [NWR*XLEN-1:0] wb_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0]  m_reg [NREGS];
    logic [NREGS-1:0] m_busy;

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wr0;
        logic [63:0] wd0;
        logic [4:0]  wr1;
        logic [63:0] wd1;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [4:0]  dbg;
        logic [63:0] e0;
        logic [63:0] e1;
        logic [1:0]  eb;
        logic [63:0] edbg;
    } vec_t;

    vec_t tbl [15];

    gpr_file_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_wen    (wb_wen),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wen, input logic [4:0] wr0, input logic [63:0] wd0,
                         input logic [4:0] wr1, input logic [63:0] wd1, input logic iv,
                         input logic [4:0] ird, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [4:0] dbg);
        wb_wen    = wen;
        wb_rd     = {wr1, wr0};
        wb_data   = {wd1, wd0};
        iss_valid = iv;
        iss_rd    = ird;
        rd_addr   = {ra1, ra0};
        dbg_addr  = dbg;
    endtask

    task automatic drive_idle(input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] dbg);
        drive(2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 1'b0, 5'd0, ra0, ra1, dbg);
    endtask

    // Reference: value a reader sees = last enabled port writing it this cycle, else stored
    function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (a == '0) return '0;
        v = m_reg[a];
        for (int unsigned p = 0; p < NWR; p++) begin
            if (wb_wen[p] && wb_rd[p*AW +: AW] == a) v = wb_data[p*XLEN +: XLEN];
        end
        return v;
    endfunction

    function automatic logic m_rbusy(input logic [AW-1:0] a);
        logic written;
        logic issued;
        written = 1'b0;
        for (int unsigned p = 0; p < NWR; p++) begin
            if (wb_wen[p] && wb_rd[p*AW +: AW] == a) written = 1'b1;
        end
        issued = iss_valid && (iss_rd == a);
        return (a != '0) && m_busy[a] && !(written && !issued);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < int'(NREGS); r++) m_reg[r] = '0;
        m_busy = '0;
    endtask

    task automatic model_commit();
        if (rst) return;
        for (int unsigned p = 0; p < NWR; p++) begin
            if (wb_wen[p] && wb_rd[p*AW +: AW] != '0) begin
                m_reg[wb_rd[p*AW +: AW]] = wb_data[p*XLEN +: XLEN];
                m_busy[wb_rd[p*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid && iss_rd != '0) m_busy[iss_rd] = 1'b1;
    endtask

    task automatic check_model(input string tag);
        for (int unsigned j = 0; j < NRD; j++) begin
            chk64($sformatf("%s rd_data[%0d]", tag, j), rd_data[j*XLEN +: XLEN], m_read(rd_addr[j*AW +: AW]));
            chk1($sformatf("%s rd_busy[%0d]", tag, j), rd_busy[j], m_rbusy(rd_addr[j*AW +: AW]));
        end
        chk64($sformatf("%s dbg_data", tag), dbg_data, m_reg[dbg_addr]);
    endtask

    function automatic logic [AW-1:0] rnd_idx();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, NREGS - 1));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    initial begin
        tbl[0]  = '{2'b00, 5'd0,  64'h0,     5'd0, 64'h0,   1'b0, 5'd0, 5'd1, 5'd31, 5'd5,  64'h0,   64'h0,   2'b00, 64'h0};
        tbl[1]  = '{2'b01, 5'd5,  V,         5'd0, 64'h0,   1'b0, 5'd0, 5'd5, 5'd6,  5'd5,  V,       64'h0,   2'b00, 64'h0};
        tbl[2]  = '{2'b00, 5'd0,  64'h0,     5'd0, 64'h0,   1'b0, 5'd0, 5'd5, 5'd0,  5'd5,  V,       64'h0,   2'b00, V};
        tbl[3]  = '{2'b11, 5'd7,  64'hAA,    5'd7, 64'hBB,  1'b0, 5'd0, 5'd7, 5'd7,  5'd7,  64'hBB,  64'hBB,  2'b00, 64'h0};
        tbl[4]  = '{2'b00, 5'd0,  64'h0,     5'd0, 64'h0,   1'b0, 5'd0, 5'd7, 5'd5,  5'd7,  64'hBB,  V,       2'b00, 64'hBB};
        tbl[5]  = '{2'b01, 5'd0,  64'hFFFF,  5'd0, 64'h0,   1'b1, 5'd0, 5'd0, 5'd0,  5'd0,  64'h0,   64'h0,   2'b00, 64'h0};
        tbl[6]  = '{2'b00, 5'd0,  64'h0,     5'd0, 64'h0,   1'b0, 5'd0, 5'd0, 5'd7,  5'd0,  64'h0,   64'hBB,  2'b00, 64'h0};
        tbl[7]  = '{2'b00, 5'd0,  64'h0,     5'd0, 64'h0,   1'b1, 5'd9, 5'd9, 5'd9,  5'd9,  64'h0,   64'h0,   2'b00, 64'h0};
        tbl[8]  = '{2'b00, 5'd0,  64'h0,     5'd0, 64'h0,   1'b0, 5'd0, 5'd9, 5'd9,  5'd9,  64'h0,   64'h0,   2'b11, 64'h0};
        tbl[9]  = '{2'b10, 5'd0,  64'h0,     5'd9, 64'h99,  1'b1, 5'd9, 5'd9, 5'd9,  5'd9,  64'h99,  64'h99,  2'b11, 64'h0};
        tbl[10] = '{2'b00, 5'd0,  64'h0,     5'd0, 64'h0,   1'b0, 5'd0, 5'd9, 5'd9,  5'd9,  64'h99,  64'h99,  2'b11, 64'h99};
        tbl[11] = '{2'b01, 5'd9,  64'h100,   5'd0, 64'h0,   1'b0, 5'd0, 5'd9, 5'd9,  5'd9,  64'h100, 64'h100, 2'b00, 64'h99};
        tbl[12] = '{2'b00, 5'd0,  64'h0,     5'd0, 64'h0,   1'b0, 5'd0, 5'd9, 5'd9,  5'd9,  64'h100, 64'h100, 2'b00, 64'h100};
        tbl[13] = '{2'b11, 5'd12, 64'h12,    5'd3, 64'h55,  1'b1, 5'd3, 5'd3, 5'd12, 5'd3,  64'h55,  64'h12,  2'b00, 64'h0};
        tbl[14] = '{2'b00, 5'd0,  64'h0,     5'd0, 64'h0,   1'b0, 5'd0, 5'd3, 5'd12, 5'd12, 64'h55,  64'h12,  2'b01, 64'h12};

        // Power-on reset: stored state reads zero while rst is high
        rst = 1'b1;
        drive_idle(5'd3, 5'd31, 5'd3);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk64("por rd_data[0]", rd_data[63:0], 64'h0);
        chk1("por rd_busy[0]", rd_busy[0], 1'b0);
        rst = 1'b0;

        // All registers read zero and idle after reset
        for (int a = 1; a < int'(NREGS); a++) begin
            drive_idle(AW'(a), AW'(a), AW'(a));
            @(negedge clk);
            chk64($sformatf("rst x%0d rd_data", a), rd_data[XLEN +: XLEN], 64'h0);
            chk1($sformatf("rst x%0d rd_busy", a), rd_busy[0], 1'b0);
            chk64($sformatf("rst x%0d dbg", a), dbg_data, 64'h0);
            next_cycle();
        end

        // Directed vectors: bypass, port priority, x0, busy set/clear ordering
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].wen, tbl[i].wr0, tbl[i].wd0, tbl[i].wr1, tbl[i].wd1,
                  tbl[i].iv, tbl[i].ird, tbl[i].ra0, tbl[i].ra1, tbl[i].dbg);
            @(negedge clk);
            chk64($sformatf("vec%0d rd_data[0]", i), rd_data[63:0], tbl[i].e0);
            chk64($sformatf("vec%0d rd_data[1]", i), rd_data[127:64], tbl[i].e1);
            chk1($sformatf("vec%0d rd_busy[0]", i), rd_busy[0], tbl[i].eb[0]);
            chk1($sformatf("vec%0d rd_busy[1]", i), rd_busy[1], tbl[i].eb[1]);
            chk64($sformatf("vec%0d dbg_data", i), dbg_data, tbl[i].edbg);
            next_cycle();
        end

        // Mid-cycle reset with x3 busy and holding 0x55: cleared before any clock edge
        drive_idle(5'd3, 5'd12, 5'd3);
        #2;
        chk1("pre-rst x3 busy", rd_busy[0], 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        chk64("async rst x3 data", rd_data[63:0], 64'h0);
        chk1("async rst x3 busy", rd_busy[0], 1'b0);
        chk64("async rst x3 dbg", dbg_data, 64'h0);
        chk64("async rst x12 data", rd_data[127:64], 64'h0);

        // Writes/issues under reset: bypass visible, but nothing is retained
        drive(2'b01, 5'd4, 64'h44, 5'd0, 64'h0, 1'b1, 5'd4, 5'd4, 5'd4, 5'd4);
        #1;
        chk64("rst bypass x4", rd_data[63:0], 64'h44);
        chk1("rst busy x4", rd_busy[0], 1'b0);
        next_cycle();
        rst = 1'b0;
        drive_idle(5'd4, 5'd3, 5'd4);
        @(negedge clk);
        chk64("post-rst x4 dropped", rd_data[63:0], 64'h0);
        chk1("post-rst x4 not busy", rd_busy[0], 1'b0);
        chk64("post-rst x4 dbg", dbg_data, 64'h0);
        next_cycle();

        // Random traffic with occasional reset pulses, checked against the array model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            if (rst) model_reset();
            drive(2'($urandom), rnd_idx(), {$urandom, $urandom}, rnd_idx(), {$urandom, $urandom},
                  1'($urandom), rnd_idx(), rnd_idx(), rnd_idx(), rnd_idx());
            @(negedge clk);
            check_model($sformatf("rnd%0d", i));
            next_cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
